lns_gauss_lut_pipe: RTL and testbench
=====================================

Name: lns_gauss_lut_pipe

Overview:
- Pipelined, parametrised evaluator for the LNS Gaussian-log correction functions used by the LNS fused multiply-add datapath.
  - op=0 (add): sb(d) = log2(1 + 2^-d)
  - op=1 (sub): db(d) = log2(1 - 2^-d)
- Two-segment table, replacing the fixed single-function fine/coarse lookup tables:
  - fine segment at full fractional resolution for d < 1
  - coarse segment indexed by the integer part of d
- Valid/ready handshake with a passthrough tag, so it sits between the operand-difference stage and the final exponent adder.

Parameters:
- FRAC_BITS, 5, fraction bits of d and of out (scale S = 2^FRAC_BITS).
- INT_BITS, 5, integer bits of d; coarse table has 2^INT_BITS entries.
- OUT_W, 11, signed output width; saturation value SAT = -2^(OUT_W-1).
- ESS_ZERO, 24, integer part of d at or above which out = 0 for both functions.
- TAG_W, 4, width of the passthrough tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_d  in  INT_BITS+FRAC_BITS  unsigned fixed-point difference d >= 0
- in_op  in  1  0 = sb (add), 1 = db (sub)
- in_tag  in  TAG_W  opaque tag returned with the result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_val  out  OUT_W  signed fixed-point result, FRAC_BITS fraction bits
- out_op  out  1  op of the result beat
- out_tag  out  TAG_W  tag of the result beat

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - all stage valid bits are cleared; out_valid = 0.
  - out_val, out_op and out_tag are 0.
  - in_ready = 1 from the first cycle after reset deassertion.
- Pipeline: three register stages.
  - S0: capture d/op/tag; classify as fine (int part = 0), coarse, or zero (int part >= ESS_ZERO).
  - S1: table read, registered.
  - S2: interpolation (optional) and output register.
- Latency and throughput: latency 3 cycles from the accepted beat to out_valid. Throughput is 1 beat/cycle when out_ready stays high.
- Flow control:
  - Each stage advances when it is empty or when its successor advances. S2 advances when !out_valid || out_ready.
  - in_ready = !S0_valid || S0_advances. Bubbles collapse.
  - While out_valid=1 && out_ready=0, out_val/out_op/out_tag hold stable.
- Tables:
  - fine_sb[k], fine_db[k] for k = 0..2^FRAC_BITS-1, with d = k/S.
  - coarse_sb[i], coarse_db[i] for i = 0..2^INT_BITS-1, with d = i.
  - entry = round-half-away-from-zero(S * f(d)), clamped to [SAT, 2^(OUT_W-1)-1].
  - db(0) = -inf maps to SAT. Coarse entries for i >= ESS_ZERO are 0.
  - Contents are built at elaboration by constant functions.
- Selection:
  - fine: entry at the fraction bits of d.
  - coarse (without interpolation): entry at the integer part of d; the fraction is truncated.
  - zero: 0.
- Simultaneous accept and emit in the same cycle are legal; no beat may be lost or duplicated.
- Reset asserted mid-operation flushes all in-flight beats. Those beats are never emitted.
- in_d, in_op and in_tag are ignored while in_valid=0 or in_ready=0.

Optional Feature:
- Macro: LNS_LUT_INTERP_EN.
- Defined: coarse-segment results are linearly interpolated in S2.
  - out = T[i] + (((T[i+1] - T[i]) * frac) >>> FRAC_BITS), arithmetic shift (floor).
  - T[i+1] is taken as 0 when i+1 >= ESS_ZERO or when i = 2^INT_BITS-1.
  - The fine segment and zero region are unchanged. Latency is unchanged (3).
- Undefined: no interpolation; coarse results are truncated as above.

Test Plan:
- Reset and basic function, defaults, single beats: sub d=0 -> SAT (-1024); sub d=32 (1.0) -> -32; add d=0 -> +32; add d=32 -> +19; sub d=64 -> -13. Each out_valid exactly 3 cycles after accept; tag echoed.
- Interpolation, sub d=48 (1.5): with LNS_LUT_INTERP_EN -> -23; without -> -32. sub d=24*32 (int part 24) -> 0 in both builds.
- Throughput: 16 back-to-back beats with out_ready=1 -> 16 results on consecutive cycles, in order, in_ready never low.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with the pipeline streaming -> in_ready drops after 3 beats are buffered; out_val/out_tag remain stable.
  - Release out_ready -> all beats emitted in order, none lost or duplicated.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately (asynchronous). After release no stale beat appears, and a new beat returns after 3 cycles.
- Boundary sweep: every d in 0..1023 for both ops, compared against the reference model, including d=31 (fine top) and d=32 (coarse entry), and the last coarse index (d=1023).

Source files
------------

// File: rtl/lns_gauss_lut_pipe.sv
// lns_gauss_lut_pipe: 3-stage LNS Gaussian-log sb/db table evaluator.
// Define LNS_LUT_INTERP_EN to linearly interpolate the coarse segment.
module lns_gauss_lut_pipe #(
  parameter int FRAC_BITS = 5,
  parameter int INT_BITS  = 5,
  parameter int OUT_W     = 11,
  parameter int ESS_ZERO  = 24,
  parameter int TAG_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INT_BITS+FRAC_BITS-1:0] in_d,
  input  logic                          in_op,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_val,
  output logic                          out_op,
  output logic [TAG_W-1:0]              out_tag
);

  localparam int D_W  = INT_BITS + FRAC_BITS;
  localparam int NF   = 1 << FRAC_BITS;
  localparam int NC   = 1 << INT_BITS;
  localparam int SAT  = -(1 << (OUT_W - 1));
  localparam int SMAX = (1 << (OUT_W - 1)) - 1;

  typedef logic signed [OUT_W-1:0] val_t;
  typedef enum logic [1:0] {
    C_FINE,
    C_COARSE,
    C_ZERO
  } cls_t;

  // S * log2(1 +/- 2^-d), rounded half away from zero and clamped
  function automatic int lut_entry(input logic op, input real d);
    real f;
    real v;
    real r;
    int  q;
    f = op ? (1.0 - 2.0 ** (-d)) : (1.0 + 2.0 ** (-d));
    if (f <= 0.0) begin
      q = SAT;
    end else begin
      v = $ln(f) / $ln(2.0) * $itor(NF);
      r = (v >= 0.0) ? $floor(v + 0.5) : -$floor(0.5 - v);
      if (r < $itor(SAT))
        q = SAT;
      else if (r > $itor(SMAX))
        q = SMAX;
      else
        q = $rtoi(r);
    end
    return q;
  endfunction

  val_t fine_sb   [NF];
  val_t fine_db   [NF];
  val_t coarse_sb [NC];
  val_t coarse_db [NC];

  for (genvar k = 0; k < NF; k++) begin : g_fine
    localparam int SB = lut_entry(1'b0, $itor(k) / $itor(NF));
    localparam int DB = lut_entry(1'b1, $itor(k) / $itor(NF));
    assign fine_sb[k] = val_t'(SB);
    assign fine_db[k] = val_t'(DB);
  end

  for (genvar i = 0; i < NC; i++) begin : g_coarse
    localparam int SB = (i >= ESS_ZERO) ? 0 : lut_entry(1'b0, $itor(i));
    localparam int DB = (i >= ESS_ZERO) ? 0 : lut_entry(1'b1, $itor(i));
    assign coarse_sb[i] = val_t'(SB);
    assign coarse_db[i] = val_t'(DB);
  end

  logic adv1;
  logic adv2;
  logic acc;

  logic                v0;
  logic [INT_BITS-1:0] ip0;
  logic [FRAC_BITS-1:0] fr0;
  logic                op0;
  logic [TAG_W-1:0]    tag0;
  cls_t                cls0;
  cls_t                cls_in;

  logic                v1;
  val_t                lo1;
  logic                op1;
  logic [TAG_W-1:0]    tag1;
  val_t                rd_lo;
  val_t                res;

  logic                v2;

  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = !v0 || adv1;
  assign acc      = in_valid && in_ready;

  always_comb begin
    cls_in = C_COARSE;
    if (int'(in_d[D_W-1:FRAC_BITS]) >= ESS_ZERO)
      cls_in = C_ZERO;
    else if (in_d[D_W-1:FRAC_BITS] == '0)
      cls_in = C_FINE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (in_ready) v0 <= in_valid;
      if (adv1)     v1 <= v0;
      if (adv2)     v2 <= v1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip0  <= '0;
      fr0  <= '0;
      op0  <= 1'b0;
      tag0 <= '0;
      cls0 <= C_FINE;
    end else if (acc) begin
      ip0  <= in_d[D_W-1:FRAC_BITS];
      fr0  <= in_d[FRAC_BITS-1:0];
      op0  <= in_op;
      tag0 <= in_tag;
      cls0 <= cls_in;
    end
  end

  always_comb begin
    rd_lo = '0;
    unique case (1'b1)
      (cls0 == C_FINE):   rd_lo = op0 ? fine_db[fr0] : fine_sb[fr0];
      (cls0 == C_COARSE): rd_lo = op0 ? coarse_db[ip0] : coarse_sb[ip0];
      default:            rd_lo = '0;
    endcase
  end

`ifdef LNS_LUT_INTERP_EN
  localparam int PW = OUT_W + FRAC_BITS + 2;

  logic [INT_BITS-1:0]  ip_nx;
  val_t                 rd_hi;
  val_t                 hi1;
  logic [FRAC_BITS-1:0] fr1;
  logic                 co1;
  logic signed [OUT_W:0] diff;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] sh;

  // Upper knot is zero past the essential-zero point or the table end
  always_comb begin
    ip_nx = ip0 + INT_BITS'(1);
    rd_hi = '0;
    if ((int'(ip0) + 1 < ESS_ZERO) && (ip0 != INT_BITS'(NC - 1)))
      rd_hi = op0 ? coarse_db[ip_nx] : coarse_sb[ip_nx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi1 <= '0;
      fr1 <= '0;
      co1 <= 1'b0;
    end else if (adv1 && v0) begin
      hi1 <= rd_hi;
      fr1 <= fr0;
      co1 <= (cls0 == C_COARSE);
    end
  end

  always_comb begin
    diff = {hi1[OUT_W-1], hi1} - {lo1[OUT_W-1], lo1};
    prod = PW'(diff) * PW'($signed({1'b0, fr1}));
    sh   = prod >>> FRAC_BITS;
    res  = lo1;
    if (co1)
      res = lo1 + val_t'(sh);
  end
`else
  assign res = lo1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo1  <= '0;
      op1  <= 1'b0;
      tag1 <= '0;
    end else if (adv1 && v0) begin
      lo1  <= rd_lo;
      op1  <= op0;
      tag1 <= tag0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val <= '0;
      out_op  <= 1'b0;
      out_tag <= '0;
    end else if (adv2 && v1) begin
      out_val <= res;
      out_op  <= op1;
      out_tag <= tag1;
    end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_lns_gauss_lut_pipe.sv
// Testbench for lns_gauss_lut_pipe: directed vectors, streaming,
// backpressure, reset flush, random traffic and a full d sweep.
module tb_lns_gauss_lut_pipe;

  localparam int FB   = 5;
  localparam int IB   = 5;
  localparam int OW   = 11;
  localparam int EZ   = 24;
  localparam int TW   = 4;
  localparam int S    = 32;
  localparam int SAT  = -1024;
  localparam int SMAX = 1023;
`ifdef LNS_LUT_INTERP_EN
  localparam int EXP48 = -23;
`else
  localparam int EXP48 = -32;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid;
  logic                 in_ready;
  logic [IB+FB-1:0]     in_d;
  logic                 in_op;
  logic [TW-1:0]        in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_val;
  logic                 out_op;
  logic [TW-1:0]        out_tag;

  lns_gauss_lut_pipe #(
    .FRAC_BITS(FB), .INT_BITS(IB), .OUT_W(OW),
    .ESS_ZERO(EZ), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_d(in_d), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_val(out_val), .out_op(out_op), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain real-valued math of the Gaussian-log functions
  function automatic int f_tab(input bit op, input real d);
    real x;
    real v;
    real r;
    if (op && d == 0.0) return SAT;
    x = op ? 1.0 - 2.0 ** (-d) : 1.0 + 2.0 ** (-d);
    v = $itor(S) * $ln(x) / $ln(2.0);
    r = (v < 0.0) ? -$floor(-v + 0.5) : $floor(v + 0.5);
    if (r < $itor(SAT)) r = $itor(SAT);
    if (r > $itor(SMAX)) r = $itor(SMAX);
    return $rtoi(r);
  endfunction

  function automatic int model(input bit op, input int d);
    int ip;
    int fr;
    int t0;
    int t1;
    ip = d / S;
    fr = d % S;
    if (ip >= EZ) return 0;
    if (ip == 0) return f_tab(op, $itor(fr) / $itor(S));
    t0 = f_tab(op, $itor(ip));
`ifdef LNS_LUT_INTERP_EN
    t1 = (ip + 1 >= EZ || ip == (1 << IB) - 1) ? 0 : f_tab(op, $itor(ip + 1));
    return t0 + (((t1 - t0) * fr) >>> FB);
`else
    t1 = 0;
    return t0 + t1;
`endif
  endfunction

  typedef struct {
    int            val;
    bit            op;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   pop_cyc[$];
  int   n_pop = 0;
  bit   hold = 1'b0;
  int   h_val;
  int   h_tag;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_val", int'(out_val), h_val);
        check("hold_tag", int'(out_tag), h_tag);
      end
      if (out_valid && out_ready) begin
        check("pop_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("out_val", int'(out_val), e.val);
          check("out_op", int'(out_op), int'(e.op));
          check("out_tag", int'(out_tag), int'(e.tag));
          n_pop++;
          pop_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready)
        q.push_back('{model(in_op, int'(in_d)), in_op, in_tag});
      hold  = out_valid && !out_ready;
      h_val = int'(out_val);
      h_tag = int'(out_tag);
    end
  end

  typedef struct {
    int            d;
    bit            op;
    logic [TW-1:0] tag;
    int            exp;
    string         name;
  } vec_t;

  vec_t vt[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input vec_t v);
    int n;
    in_valid = 1'b1;
    in_d     = 10'(v.d);
    in_op    = v.op;
    in_tag   = v.tag;
    step();
    in_valid = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      if (out_valid) break;
      step();
      n++;
    end
    check({v.name, "_lat"}, n, 3);
    check(v.name, int'(out_val), v.exp);
    check({v.name, "_tag"}, int'(out_tag), int'(v.tag));
    step();
  endtask

  task automatic drain(input string name);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      step();
      n++;
    end
    repeat (3) step();
    check(name, q.size(), 0);
  endtask

  initial begin
    int  nacc;
    int  stale;
    int  spread;
    bit  a;
    bit  pend;
    vec_t vpost;

    in_valid  = 1'b0;
    in_d      = '0;
    in_op     = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;

    vt = '{
      '{0,    1'b1, 4'd1,  -1024, "sub_d0"},
      '{32,   1'b1, 4'd2,  -32,   "sub_d32"},
      '{0,    1'b0, 4'd3,  32,    "add_d0"},
      '{32,   1'b0, 4'd4,  19,    "add_d32"},
      '{64,   1'b1, 4'd5,  -13,   "sub_d64"},
      '{48,   1'b1, 4'd6,  EXP48, "sub_d48"},
      '{768,  1'b1, 4'd7,  0,     "sub_d768"},
      '{31,   1'b0, 4'd8,  19,    "add_d31"},
      '{31,   1'b1, 4'd9,  -33,   "sub_d31"},
      '{1023, 1'b1, 4'd10, 0,     "sub_d1023"}
    };

    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_val", int'(out_val), 0);
    check("rst_out_tag", int'(out_tag), 0);
    check("rst_out_op", int'(out_op), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_idle_valid", int'(out_valid), 0);
    step();

    foreach (vt[i]) single(vt[i]);

    // Back-to-back stream
    pop_cyc.delete();
    n_pop = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_d     = 10'($urandom_range(0, 1023));
      in_op    = 1'($urandom);
      in_tag   = 4'(i);
      @(negedge clk);
      check("thr_in_ready", int'(in_ready), 1);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    check("thr_count", n_pop, 16);
    spread = (pop_cyc.size() == 16) ? pop_cyc[15] - pop_cyc[0] : -1;
    check("thr_consecutive", spread, 15);

    // Backpressure: three beats fill the pipe, then in_ready drops
    n_pop     = 0;
    nacc      = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_d      = 10'($urandom_range(0, 1023));
    in_op     = 1'($urandom);
    in_tag    = 4'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a = in_ready;
      if (c >= 3) check("bp_in_ready_low", int'(in_ready), 0);
      if (a) nacc++;
      step();
      if (a) begin
        in_d   = 10'($urandom_range(0, 1023));
        in_op  = 1'($urandom);
        in_tag = in_tag + 4'd1;
      end
    end
    check("bp_accepts", nacc, 3);
    drain("bp_drain_empty");
    check("bp_emitted", n_pop, 3);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_d     = 10'(32 * (i + 1));
      in_op    = 1'b0;
      in_tag   = 4'(12 + i);
      step();
    end
    in_valid = 1'b0;
    check("rst_pre_valid", int'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_valid", int'(out_valid), 0);
    check("rst_async_val", int'(out_val), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
      step();
    end
    check("rst_no_stale", stale, 0);
    vpost = '{32, 1'b0, 4'd9, 19, "post_rst_add_d32"};
    single(vpost);

    // Random traffic with random backpressure
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_d     = 10'($urandom_range(0, 1023));
        in_op    = 1'($urandom);
        in_tag   = in_tag + 4'd1;
      end
      @(negedge clk);
      pend = in_valid && !in_ready;
      step();
    end
    drain("rand_drain_empty");

    // Full sweep of d for both ops
    out_ready = 1'b1;
    for (int op = 0; op < 2; op++) begin
      for (int d = 0; d < 1024; d++) begin
        in_valid = 1'b1;
        in_d     = 10'(d);
        in_op    = 1'(op);
        in_tag   = 4'(d);
        step();
      end
    end
    drain("sweep_drain_empty");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
